// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage integer ALU with the RV32M/RV64M multiply, divide and
// remainder operations behind a valid/ready handshake.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   flush           abort the in-flight op; blocks acceptance this cycle
//   in_valid        operands and op present
//   in_ready        block can accept an op (state is IDLE)
//   a, b            operands
//   alu_controls    op select (0x00-0x0D base, 0x10-0x13 mul, 0x14-0x17 div)
//   funct3b0        inverts the branch-compare results (0x0A-0x0C)
//   res             registered result, held until the next out_valid
//   out_valid       one-cycle pulse per completed op
//   busy            multiply or divide in flight
//
// Latency: base ops and divide special cases 1, multiply 2,
// divide/remainder DATA_WIDTH+2.
module alu_mdu #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [5:0]            alu_controls,
  input  logic                  funct3b0,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int DW    = DATA_WIDTH;
  localparam int PW    = 2 * DATA_WIDTH + 2;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  // Single-cycle integer operations; unlisted codes yield zero.
  function automatic logic [DW-1:0] base_op(input logic [DW-1:0] x,
                                            input logic [DW-1:0] y,
                                            input logic [5:0]    op,
                                            input logic          inv);
    logic [SHAMT_W-1:0] sh;
    logic               eq;
    logic               lt;
    logic               ltu;
    logic [DW-1:0]      r;
    sh  = y[SHAMT_W-1:0];
    eq  = (x == y);
    lt  = ($signed(x) < $signed(y));
    ltu = (x < y);
    case (op)
      6'h00:   r = x + y;
      6'h01:   r = x - y;
      6'h02:   r = x << sh;
      6'h03:   r = {{(DW-1){1'b0}}, lt};
      6'h04:   r = {{(DW-1){1'b0}}, ltu};
      6'h05:   r = x ^ y;
      6'h06:   r = x >> sh;
      6'h07:   r = $signed(x) >>> sh;
      6'h08:   r = x | y;
      6'h09:   r = x & y;
      6'h0A:   r = {{(DW-1){1'b0}}, eq ^ inv};
      6'h0B:   r = {{(DW-1){1'b0}}, ltu ^ inv};
      6'h0C:   r = {{(DW-1){1'b0}}, lt ^ inv};
      6'h0D:   r = y;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Two's-complement negate when requested (magnitude in, signed result out).
  function automatic logic [DW-1:0] neg_if(input logic [DW-1:0] v,
                                           input logic          n);
    return n ? (~v + 1'b1) : v;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             vld_p2;
  logic [DW-1:0]    res_p2;

  logic signed [PW-1:0] prod_p1;
  logic                 mul_hi_p1;
  logic                 div_rem_p1;
  logic                 q_neg_p1;
  logic                 r_neg_p1;
  logic [DW-1:0]        quo_p1;
  logic [DW-1:0]        rem_p1;
  logic [DW-1:0]        dvs_p1;

  logic accept;
  logic is_mul;
  logic is_div;
  logic div_sgn;
  logic div_rem;
  logic div_zero;
  logic div_ovf;
  logic a_neg;
  logic b_neg;
  logic mul_a_sgn;
  logic mul_b_sgn;

  logic [DW-1:0]        fast_res;
  logic signed [DW:0]   ma;
  logic signed [DW:0]   mb;
  logic signed [PW-1:0] ma_x;
  logic signed [PW-1:0] mb_x;
  logic signed [PW-1:0] prod_full;
  logic [DW-1:0]        mul_res;
  logic [DW:0]          rem_sh;
  logic [DW:0]          diff;
  logic [DW-1:0]        div_final;
  logic [1:0]           unused_prod_top;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign res       = res_p2;
  assign out_valid = vld_p2;

  assign is_mul   = (alu_controls[5:2] == 4'b0100);
  assign is_div   = (alu_controls[5:2] == 4'b0101);
  assign div_sgn  = !alu_controls[0];
  assign div_rem  = alu_controls[1];
  assign div_zero = (b == '0);
  assign div_ovf  = div_sgn && (a == MIN_NEG) && (b == '1);
  assign a_neg    = div_sgn && a[DW-1];
  assign b_neg    = div_sgn && b[DW-1];

  // Divide special cases bypass the iterative path and complete like base ops.
  always_comb begin
    fast_res = base_op(a, b, alu_controls, funct3b0);
    if (is_div) begin
      if (div_zero) fast_res = div_rem ? a : '1;
      else          fast_res = div_rem ? '0 : a;
    end
  end

  // MULHU is the only unsigned-a op; MULHSU and MULHU take b unsigned.
  assign mul_a_sgn = !(alu_controls[1] && alu_controls[0]);
  assign mul_b_sgn = !alu_controls[1];
  assign ma        = {mul_a_sgn && a[DW-1], a};
  assign mb        = {mul_b_sgn && b[DW-1], b};
  assign ma_x      = {{(DW+1){ma[DW]}}, ma};
  assign mb_x      = {{(DW+1){mb[DW]}}, mb};
  assign prod_full = ma_x * mb_x;

  // The two guard bits only carry sign extension; results use the low 2*DW.
  assign unused_prod_top = prod_p1[PW-1:2*DW];
  assign mul_res = mul_hi_p1 ? prod_p1[2*DW-1:DW] : prod_p1[DW-1:0];

  // Restoring step: shift the next dividend bit into the partial remainder.
  assign rem_sh    = {rem_p1, quo_p1[DW-1]};
  assign diff      = rem_sh - {1'b0, dvs_p1};
  assign div_final = div_rem_p1 ? neg_if(rem_p1, r_neg_p1)
                                : neg_if(quo_p1, q_neg_p1);

  // ---- p0 -> p1: operand capture, product, divide iterations ----
  always_ff @(posedge clk) begin
    if (accept) begin
      prod_p1    <= prod_full;
      mul_hi_p1  <= |alu_controls[1:0];
      div_rem_p1 <= div_rem;
      q_neg_p1   <= a_neg ^ b_neg;
      r_neg_p1   <= a_neg;
      quo_p1     <= neg_if(a, a_neg);
      rem_p1     <= '0;
      dvs_p1     <= neg_if(b, b_neg);
    end else if (state == S_DIV) begin
      if (!diff[DW]) begin
        rem_p1 <= diff[DW-1:0];
        quo_p1 <= {quo_p1[DW-2:0], 1'b1};
      end else begin
        rem_p1 <= rem_sh[DW-1:0];
        quo_p1 <= {quo_p1[DW-2:0], 1'b0};
      end
    end
  end

  // ---- p1 -> p2: sequencing and registered result ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      vld_p2 <= 1'b0;
      res_p2 <= '0;
    end else begin
      vld_p2 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state <= S_MUL;
            end else if (is_div && !div_zero && !div_ovf) begin
              state <= S_DIV;
              cnt   <= CNT_W'(DW - 1);
            end else begin
              res_p2 <= fast_res;
              vld_p2 <= 1'b1;
            end
          end
        end
        S_MUL: begin
          state <= S_IDLE;
          if (!flush) begin
            res_p2 <= mul_res;
            vld_p2 <= 1'b1;
          end
        end
        S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!flush) begin
            res_p2 <= div_final;
            vld_p2 <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
